// File: rtl/i2s_mic_rx.sv
// I2S receiver for a stereo pair of 18-bit MEMS mics: generates BCLK/WS,
// deserialises both slots and strobes out time-aligned left/right samples.

module i2s_mic_rx_lane #(
  parameter int W = 18
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] sr
);
  always_ff @(posedge clock) begin
    if (reset)         sr <= '0;
    else if (shift_en) sr <= {sr[W-2:0], bit_in};
  end
endmodule

module i2s_mic_rx #(
  parameter int CLK_DIV        = 16,
  parameter int DISCARD_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sd,
  output logic        bclk,
  output logic        ws,
  output logic [17:0] data_l,
  output logic [17:0] data_r,
  output logic        data_rdy
);
  localparam int NUM_LANES = 2;
  localparam int SW        = 18;
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW        = (DISCARD_FRAMES > 0) ? $clog2(DISCARD_FRAMES + 1) : 1;

  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt, bit_cnt_next;
  logic [FW-1:0] frames_seen;
  logic          sd_meta, sd_sync;
  logic          tick, rise, fall, cap, done;
  logic [4:0]    slot_pos;

  logic [NUM_LANES-1:0]         shift_en;
  logic [NUM_LANES-1:0][SW-1:0] sr;

  assign tick     = (div_cnt == DW'(CLK_DIV - 1));
  assign rise     = tick & ~bclk;
  assign fall     = tick & bclk;
  assign slot_pos = bit_cnt[4:0];
  // One-bit I2S delay: MSB lands on p=1, LSB on p=18.
  assign cap      = rise && (slot_pos >= 5'd1) && (slot_pos <= 5'd18);
  assign done     = rise && (bit_cnt == 6'd50);

  always_comb begin
    bit_cnt_next = bit_cnt;
    if (fall) bit_cnt_next = bit_cnt + 6'd1;
  end

  genvar ch;
  generate
    for (ch = 0; ch < NUM_LANES; ch++) begin : g_lane
      localparam logic CH_SEL = 1'(ch);
      assign shift_en[ch] = cap & (bit_cnt[5] == CH_SEL);
      i2s_mic_rx_lane #(.W(SW)) u_lane (
        .clock    (clock),
        .reset    (reset),
        .shift_en (shift_en[ch]),
        .bit_in   (sd_sync),
        .sr       (sr[ch])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      sd_meta     <= 1'b0;
      sd_sync     <= 1'b0;
      div_cnt     <= '0;
      bclk        <= 1'b0;
      bit_cnt     <= '0;
      ws          <= 1'b0;
      frames_seen <= '0;
      data_l      <= '0;
      data_r      <= '0;
      data_rdy    <= 1'b0;
    end else begin
      sd_meta  <= sd;
      sd_sync  <= sd_meta;
      div_cnt  <= tick ? '0 : div_cnt + DW'(1);
      if (tick) bclk <= ~bclk;
      bit_cnt  <= bit_cnt_next;
      ws       <= bit_cnt_next[5];
      data_rdy <= 1'b0;
      if (done) begin
        // The right LSB is still on the wire this cycle, so splice it in directly.
        if (frames_seen == FW'(DISCARD_FRAMES)) begin
          data_l   <= sr[0];
          data_r   <= {sr[1][SW-2:0], sd_sync};
          data_rdy <= 1'b1;
        end else begin
          frames_seen <= frames_seen + FW'(1);
        end
      end
    end
  end
endmodule

// File: doc/i2s_mic_rx.md
# i2s_mic_rx

Receives one I2S data line carrying a stereo pair of 18-bit MEMS microphones (left/right selected by mic strap). Generates the master BCLK and WS toward the microphones. Deserialises each slot and presents time-aligned left/right samples with a single-cycle `data_rdy` strobe. The outputs feed the sample window buffer stages directly: one buffer per channel, sharing `data_rdy`.

## Interface
- `CLK_DIV`, 16: system clocks per BCLK half-period; legal ≥ 4. At 100 MHz this gives BCLK 3.125 MHz and fs 48.83 kHz.
- `DISCARD_FRAMES`, 2: complete frames suppressed after reset, covering mic start-up.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `sd`  in  1  I2S serial data from the mics; asynchronous to `clock`.
- `bclk`  out  1  bit clock to the mics; registered.
- `ws`  out  1  word select; 0 = left slot, 1 = right slot; registered.
- `data_l`  out  18  last left sample; two's complement, raw (no rectification).
- `data_r`  out  18  last right sample, same format.
- `data_rdy`  out  1  one-cycle pulse; `data_l`/`data_r` updated in the same cycle.

## Operation
- **Reset values:** `bclk`=0, `ws`=0, `data_l`=0, `data_r`=0, `data_rdy`=0. Internal state also clears:
  - `div_cnt`=0, `bit_cnt`=0, `frames_seen`=0;
  - both shift registers 0;
  - synchroniser flops 0.
- **Divider:** `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - When `div_cnt`==CLK_DIV-1, `bclk` toggles on the next edge.
  - That cycle is a *rise event* if `bclk`==0, and a *fall event* if `bclk`==1.
- **Frame:** 64 BCLKs. `bit_cnt` (6 bits) increments mod 64 on each fall event.
  - `ws` is registered as `bit_cnt_next[5]`, so it changes only with a BCLK fall.
  - Slot position p = `bit_cnt[4:0]`; channel = `bit_cnt[5]`.
- **Input sync:** `sd` passes through a 2-flop synchroniser. The sampled value is the synchroniser output.
- **Capture:** on a rise event with p in 1..18, the synchronised bit shifts MSB-first into the channel's 18-bit shift register.
  - p=1 is the MSB (standard I2S one-bit delay after WS).
  - p=0 and p=19..31 are ignored, whatever the line carries.
- **Completion:** the rise event at `bit_cnt`==50 (right, p=18) completes a frame.
  - If `frames_seen`==DISCARD_FRAMES:
    - `data_l` ← left shift register;
    - `data_r` ← {right shift register[16:0], sampled bit};
    - `data_rdy`=1.
  - Otherwise, outputs hold, `data_rdy` stays 0, and `frames_seen` increments (saturating at DISCARD_FRAMES).
- **Hold:** outputs keep their value between strobes. The left shift register is not rewritten until p=1 of the next left slot, so pairing is always from the same frame.
- **No backpressure:** the consumer must accept each strobe. Pulses are spaced 128·CLK_DIV cycles apart.

## Timing
- Rise event for frame-bit b of frame f (counted from reset release) occurs at cycle (f·64+b)·2·CLK_DIV + CLK_DIV−1.
- `data_rdy` is high exactly one cycle later, at b=50 and f=DISCARD_FRAMES, and every frame thereafter.
  - With CLK_DIV=4 and DISCARD_FRAMES=0: cycles 404, 916, 1428, …
- Latency from the last right-data bit (p=18 rise) to the strobe: 1 cycle. The 2-cycle synchroniser lag is absorbed by the half-period margin.
- **Input window:** `sd` may change up to 1 cycle after a BCLK fall and must then be stable until the following rise. CLK_DIV ≥ 4 guarantees ≥ 2 stable cycles through the synchroniser.
- `bclk` duty is exactly 50%. `ws` transitions coincide with the cycle `bclk` goes 1→0.
- **Reset mid-frame:** on the next edge all state returns to reset values.
  - Any partial sample is dropped and the discard count restarts.
  - Timing restarts from cycle 0 after reset deasserts.
- Reset asserted in the same cycle as a completion: reset wins; no strobe.

## Test plan
- **Reset:** hold `reset` 5 cycles, `sd`=1 → all outputs 0; `bclk` low for the first CLK_DIV cycles after release.
- **Clock generation (CLK_DIV=4):**
  - `bclk` period 8 cycles, 50% duty;
  - `ws` toggles every 256 cycles, first at cycle 255→256, always on a `bclk` fall.
- **Single capture (CLK_DIV=4, DISCARD_FRAMES=0):** drive left 18'h2ABCD and right 18'h12345 MSB at p=1, with 1s on p=0 and p=19..31.
  - Expected: `data_rdy` high only at cycle 404, with `data_l`=18'h2ABCD and `data_r`=18'h12345.
  - Values hold through cycle 915.
- **Sign extremes:** left 18'h20000, right 18'h1FFFF → exact values returned; next frame 18'h3FFFF/0 updates at cycle 916.
- **Discard (DISCARD_FRAMES=2):** drive a valid pattern every frame → no strobe before cycle 1428; strobe at 1428 with frame-2 values.
- **Mid-frame reset:** at CLK_DIV=4, DISCARD_FRAMES=0, pulse reset at cycle 200, then send one clean frame → exactly one strobe at 404 cycles after release, with the clean frame's values.
